square_wave_generator: RTL

Consumes the 10-bit half-period count produced by wave_period_calculator and turns it into an audible square wave. It provides a 1-bit tone, a signed amplitude sample for the mixer/DAC path, and a one-cycle pulse on every tone edge. Period changes and note-off take effect only at wave boundaries, so the output never glitches or clicks mid-cycle.

---
 rtl/synth_pkg.sv | 13 +
 rtl/half_period_counter.sv | 30 +++
 rtl/square_wave_generator.sv | 114 +++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the tone-synthesis blocks.
package synth_pkg;
   localparam int HALF_PERIOD_W     = 10;
   localparam int DEFAULT_AMP_WIDTH = 8;
   localparam int DEFAULT_AMPLITUDE = 100;

   typedef logic [HALF_PERIOD_W-1:0] half_period_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } wave_state_t;
endpackage

// File: rtl/half_period_counter.sv
// Free-running half-period counter with terminal flag (cnt == period-1); clear forces cnt to zero.
// Terminal is combinational from the registered count; no backpressure.
module half_period_counter
   import synth_pkg::*;
#(
   parameter int WIDTH = HALF_PERIOD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             count,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] cnt,
   output logic             terminal
);

   // Compare cnt+1 against period one bit wider so period-1 never wraps.
   assign terminal = (({1'b0, cnt} + (WIDTH+1)'(1)) == {1'b0, period});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || (count && terminal)) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/square_wave_generator.sv
// Square-wave tone generator: registered tone, signed sample and edge pulse; period/note-off act only at half boundaries.
// First high edge on the clock that samples a valid enable/period; no backpressure.
module square_wave_generator #(
   parameter int HALF_PERIOD_W = synth_pkg::HALF_PERIOD_W,
   parameter int AMP_WIDTH     = synth_pkg::DEFAULT_AMP_WIDTH,
   parameter int AMPLITUDE     = synth_pkg::DEFAULT_AMPLITUDE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [HALF_PERIOD_W-1:0]    halfPeriodTotal,
   input  logic                        enable,
   output logic                        waveOut,
   output logic signed [AMP_WIDTH-1:0] sample,
   output logic                        edgePulse,
   output logic                        active
);
   import synth_pkg::*;

   localparam logic signed [AMP_WIDTH-1:0] AMP_POS = AMP_WIDTH'(AMPLITUDE);
   localparam logic signed [AMP_WIDTH-1:0] AMP_NEG = -AMP_POS;

   wave_state_t                 state_q, state_d;
   logic [HALF_PERIOD_W-1:0]    cur_period, cur_period_d;
   logic [HALF_PERIOD_W-1:0]    cnt;
   logic                        terminal;
   logic                        wave_d, edge_d, active_d;
   logic signed [AMP_WIDTH-1:0] sample_d;
   logic                        note_valid;

   assign note_valid = enable && (halfPeriodTotal != '0);

   half_period_counter #(
      .WIDTH (HALF_PERIOD_W)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_q == IDLE),
      .count    (state_q == RUN),
      .period   (cur_period),
      .cnt      (cnt),
      .terminal (terminal)
   );

   always_comb begin
      state_d      = state_q;
      cur_period_d = cur_period;
      wave_d       = waveOut;
      sample_d     = sample;
      edge_d       = 1'b0;
      active_d     = active;

      case (state_q)
         IDLE: begin
            wave_d   = 1'b0;
            sample_d = '0;
            active_d = 1'b0;
            if (note_valid) begin
               state_d      = RUN;
               cur_period_d = halfPeriodTotal;
               wave_d       = 1'b1;
               sample_d     = AMP_POS;
               edge_d       = 1'b1;
               active_d     = 1'b1;
            end
         end
         RUN: begin
            if (terminal) begin
               if (waveOut) begin
                  // Low half always follows a high half, regardless of enable.
                  wave_d   = 1'b0;
                  sample_d = AMP_NEG;
                  edge_d   = 1'b1;
                  if (halfPeriodTotal != '0) begin
                     cur_period_d = halfPeriodTotal;
                  end
               end else if (note_valid) begin
                  wave_d       = 1'b1;
                  sample_d     = AMP_POS;
                  edge_d       = 1'b1;
                  cur_period_d = halfPeriodTotal;
               end else begin
                  state_d  = IDLE;
                  wave_d   = 1'b0;
                  sample_d = '0;
                  active_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_period <= '0;
         waveOut    <= 1'b0;
         sample     <= '0;
         edgePulse  <= 1'b0;
         active     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_period <= cur_period_d;
         waveOut    <= wave_d;
         sample     <= sample_d;
         edgePulse  <= edge_d;
         active     <= active_d;
      end
   end

   cnt_in_range: assert property (@(posedge clk) disable iff (rst)
      (state_q == RUN) |-> (cnt < cur_period));

endmodule
